// File: rtl/pipe_pkg.sv
// Shared pipeline types for the fetch front-end: queue entry layout,
// fetch FSM state encoding and a word-alignment helper.
package pipe_pkg;

   // One buffered fetch result as presented to IF/ID.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Fetch FSM: no request, live request, or a request whose answer is stale.
   typedef enum logic [1:0] {
      IFQ_IDLE = 2'd0,
      IFQ_REQ  = 2'd1,
      IFQ_DROP = 2'd2
   } ifq_state_t;

   localparam logic [31:0] INST_BYTES = 32'd4;

   // Clear the byte offset so fetches always land on a word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// First-word-fall-through FIFO of fetch entries. Occupancy is tracked by a
// counter, pointers wrap naturally at DEPTH, and flush empties the queue by
// snapping the read pointer onto the write pointer.
module ifq_fifo
   import pipe_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int PTR_WIDTH = 2
) (
   input  logic                 clk,
   input  logic                 reset_b,
   input  logic                 push,
   input  fetch_entry_t         push_data,
   input  logic                 pop,
   input  logic                 flush,
   output logic [PTR_WIDTH:0]   count,
   output fetch_entry_t         head
);

   localparam logic [PTR_WIDTH:0] C_FULL = (PTR_WIDTH+1)'(DEPTH);

   fetch_entry_t           r_mem [DEPTH];
   logic [PTR_WIDTH-1:0]   r_rd_ptr;
   logic [PTR_WIDTH-1:0]   r_wr_ptr;
   logic [PTR_WIDTH:0]     r_count;
   logic                   w_do_pop;
   logic                   w_do_push;

   // A pop on an empty queue is ignored; a push into a full queue only lands
   // when a pop frees the head slot in the same cycle.
   assign w_do_pop  = pop & (r_count != '0);
   assign w_do_push = push & ((r_count != C_FULL) | w_do_pop);

   assign count = r_count;
   assign head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

   // Entry storage write port.
   // NOTE: storage carries no reset; entries are only ever read when count says they are valid.
   always_ff @(posedge clk) begin
      if (w_do_push && !flush) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush overrides push and pop.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + (PTR_WIDTH+1)'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - (PTR_WIDTH+1)'(1);
         end
      end
   end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: issues one sequential word fetch at a time to
// a variable-latency memory, buffers {pc, inst} in a small FWFT queue and
// restarts at a branch target on redirect, discarding any stale response.
module inst_fetch_queue
   import pipe_pkg::*;
#(
   parameter int          DEPTH     = 4,
   parameter int          PTR_WIDTH = 2,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   input  logic        out_ready
);

   localparam logic [PTR_WIDTH:0] C_DEPTH = (PTR_WIDTH+1)'(DEPTH);

   ifq_state_t          r_state;
   ifq_state_t          w_state_next;
   logic [31:0]         r_fetch_pc;
   logic [31:0]         w_fetch_pc_next;
   logic                w_push;
   logic                w_pop;
   logic [PTR_WIDTH:0]  w_count;
   logic [PTR_WIDTH:0]  w_count_after_pop;
   logic [PTR_WIDTH:0]  w_count_next;
   fetch_entry_t        w_push_entry;
   fetch_entry_t        w_head;

   assign out_valid = (w_count != '0);
   assign out_pc    = w_head.pc;
   assign out_inst  = w_head.inst;
   assign imem_req  = (r_state != IFQ_IDLE);
   assign imem_addr = r_fetch_pc;

   assign w_pop             = out_valid & out_ready;
   assign w_count_after_pop = w_count - (PTR_WIDTH+1)'(w_pop);
   assign w_count_next      = w_count_after_pop + (PTR_WIDTH+1)'(1);
   assign w_push_entry      = '{pc: r_fetch_pc, inst: imem_rdata};

   ifq_fifo #(
      .DEPTH     (DEPTH),
      .PTR_WIDTH (PTR_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .reset_b   (reset_b),
      .push      (w_push),
      .push_data (w_push_entry),
      .pop       (w_pop),
      .flush     (redirect),
      .count     (w_count),
      .head      (w_head)
   );

   // FSM state and fetch address registers.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         r_state    <= IFQ_IDLE;
         r_fetch_pc <= RESET_PC;
      end else begin
         r_state    <= w_state_next;
         r_fetch_pc <= w_fetch_pc_next;
      end
   end

   // Next-state, next fetch address and push decision; redirect wins over everything.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      w_state_next    = r_state;
      w_fetch_pc_next = r_fetch_pc;
      w_push          = 1'b0;
      if (redirect) begin
         w_fetch_pc_next = word_align(redirect_pc);
         case (r_state)
            IFQ_REQ, IFQ_DROP: w_state_next = imem_rvalid ? IFQ_REQ : IFQ_DROP;
            default:           w_state_next = IFQ_REQ;
         endcase
      end else begin
         case (r_state)
            IFQ_IDLE: begin
               // The in-flight slot is reserved up front, so a response always fits.
               if (w_count_after_pop < C_DEPTH) begin
                  w_state_next = IFQ_REQ;
               end
            end
            IFQ_REQ: begin
               if (imem_rvalid) begin
                  w_push          = 1'b1;
                  w_fetch_pc_next = r_fetch_pc + INST_BYTES;
                  w_state_next    = (w_count_next < C_DEPTH) ? IFQ_REQ : IFQ_IDLE;
               end
            end
            IFQ_DROP: begin
               // Stale answer is thrown away; fetch_pc already holds the target.
               if (imem_rvalid) begin
                  w_state_next = IFQ_REQ;
               end
            end
            default: w_state_next = IFQ_IDLE;
         endcase
      end
   end

endmodule
